// File: rtl/riscv_mem_pkg.sv
// Shared load/store encodings and FSM state type for the memory responders.
package riscv_mem_pkg;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_D  = 3'b011;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;
   localparam logic [2:0] SZ_WU = 3'b110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      EXEC = 2'd2,
      RESP = 2'd3
   } mem_state_e;

   function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
      return 4'd1 << funct3[1:0];
   endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of a little-endian load; raw[7:0] holds the lowest-addressed byte.
module load_extend
   import riscv_mem_pkg::*;
(
   input  logic [63:0] raw,
   input  logic [2:0]  size,
   output logic [63:0] data
);

   always_comb begin
      data = '0;
      case (size)
         SZ_B:    data = {{56{raw[7]}},  raw[7:0]};
         SZ_H:    data = {{48{raw[15]}}, raw[15:0]};
         SZ_W:    data = {{32{raw[31]}}, raw[31:0]};
         SZ_D:    data = raw;
         SZ_BU:   data = {56'd0, raw[7:0]};
         SZ_HU:   data = {48'd0, raw[15:0]};
         SZ_WU:   data = {32'd0, raw[31:0]};
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/data_memory_responder.sv
// Load/store responder: one request at a time, programmable wait states, byte-lane RAM.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// WAIT  | counting down wait states
// EXEC  | check access, commit store or read RAM, register response
// RESP  | rsp_valid high, held until rsp_ready
module data_memory_responder
   import riscv_mem_pkg::*;
#(
   parameter int ADDRSIZE = 8,
   parameter int WORDSIZE = 64,
   parameter int LATENCY  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [2:0]          req_size,
   input  logic [ADDRSIZE-1:0] req_addr,
   input  logic [WORDSIZE-1:0] req_wdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [WORDSIZE-1:0] rsp_rdata,
   output logic                rsp_error
);

   mem_state_e          state, state_nx;
   logic [3:0]          cnt;
   logic                a_write;
   logic [2:0]          a_size;
   logic [ADDRSIZE-1:0] a_addr;
   logic [63:0]         a_wdata;

   logic [7:0]          mem [0:(1<<ADDRSIZE)-1];
   logic [ADDRSIZE-1:0] base;
   logic [2:0]          off;
   logic [3:0]          nb;
   logic                fault;
   logic [7:0]          mask8, wmask;
   logic [63:0]         wsh, rd_raw, rd_sh, ext;

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req_valid) state_nx = (LATENCY == 0) ? EXEC : WAIT;
         WAIT:    if (cnt <= 4'd1) state_nx = EXEC;
         EXEC:    state_nx = RESP;
         RESP:    if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // The whole 8-byte word containing the access is read; aligned accesses never leave it.
   assign base  = a_addr & ~ADDRSIZE'(7);
   assign off   = a_addr[2:0];
   assign nb    = size_bytes(a_size);
   assign fault = (|(off & 3'(nb - 4'd1)))
                | (!a_write && a_size == 3'b111)
                | (a_write && a_size[2]);

   assign mask8 = 8'((16'd1 << nb) - 16'd1);
   assign wmask = mask8 << off;
   assign wsh   = a_wdata << {off, 3'b000};

   always_comb begin
      rd_raw = '0;
      for (int i = 0; i < 8; i++)
         rd_raw[i*8 +: 8] = mem[base | ADDRSIZE'(i)];
   end

   assign rd_sh = rd_raw >> {off, 3'b000};

   load_extend u_load_extend (
      .raw  (rd_sh),
      .size (a_size),
      .data (ext)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         a_write   <= 1'b0;
         a_size    <= '0;
         a_addr    <= '0;
         a_wdata   <= '0;
         rsp_rdata <= '0;
         rsp_error <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               a_write <= req_write;
               a_size  <= req_size;
               a_addr  <= req_addr;
               a_wdata <= req_wdata;
               cnt     <= 4'(LATENCY);
            end
            WAIT: cnt <= cnt - 4'd1;
            EXEC: begin
               rsp_rdata <= (fault || a_write) ? '0 : ext;
               rsp_error <= fault;
            end
            default: ;
         endcase
      end
   end

   // RAM is deliberately not reset; a store in EXEC coinciding with rst is dropped.
   always_ff @(posedge clk) begin
      if (!rst && state == EXEC && a_write && !fault) begin
         for (int i = 0; i < 8; i++)
            if (wmask[i]) mem[base | ADDRSIZE'(i)] <= wsh[i*8 +: 8];
      end
   end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: two instances (2 and 0 wait states) against a byte-array model.
module tb_data_memory_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [2:0]  req_size = '0;
   logic [7:0]  req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        rsp_ready = 1'b1;

   logic        d0_req_ready, d0_rsp_valid, d0_rsp_error;
   logic        d1_req_ready, d1_rsp_valid, d1_rsp_error;
   logic [63:0] d0_rsp_rdata, d1_rsp_rdata;
   logic        req_ready_m, rsp_valid_m, rsp_error_m;
   logic [63:0] rsp_rdata_m;

   int checks = 0;
   int errors = 0;

   logic [7:0] model_mem [2][256];

   always #5 clk = ~clk;

   data_memory_responder #(.ADDRSIZE(8), .WORDSIZE(64), .LATENCY(2)) u_dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(d0_req_ready),
      .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(d0_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(d0_rsp_rdata),
      .rsp_error(d0_rsp_error));

   data_memory_responder #(.ADDRSIZE(8), .WORDSIZE(64), .LATENCY(0)) u_dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(d1_req_ready),
      .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(d1_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(d1_rsp_rdata),
      .rsp_error(d1_rsp_error));

   assign req_ready_m = sel ? d1_req_ready : d0_req_ready;
   assign rsp_valid_m = sel ? d1_rsp_valid : d0_rsp_valid;
   assign rsp_error_m = sel ? d1_rsp_error : d0_rsp_error;
   assign rsp_rdata_m = sel ? d1_rsp_rdata : d0_rsp_rdata;

   function automatic int exp_lat();
      return sel ? 1 : 3;
   endfunction

   // Reference behaviour: byte array, little-endian assembly, arithmetic sign extension.
   function automatic void model_access(input bit w, input logic [2:0] sz, input logic [7:0] a,
                                        input logic [63:0] wd, output logic [63:0] rd,
                                        output logic er);
      int nb;
      logic [63:0] v;
      int s;
      s  = sel ? 1 : 0;
      nb = 1 << sz[1:0];
      rd = '0;
      er = ((int'(a) % nb) != 0) || (!w && sz == 3'b111) || (w && sz[2]);
      if (er) return;
      if (w) begin
         for (int k = 0; k < nb; k++) model_mem[s][int'(a) + k] = wd[8*k +: 8];
         return;
      end
      v = '0;
      for (int k = 0; k < nb; k++) v = v | (64'(model_mem[s][int'(a) + k]) << (8*k));
      if (!sz[2] && nb < 8 && v[8*nb-1]) v = v - (64'd1 << (8*nb));
      rd = v;
   endfunction

   // Drives one request with rsp_ready high and returns what the DUT answered.
   task automatic txn(input bit w, input logic [2:0] sz, input logic [7:0] a,
                      input logic [63:0] wd, output logic [63:0] rd, output logic er,
                      output int lat, output bit to);
      int n;
      to = 1'b0;
      n  = 0;
      @(negedge clk);
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
      while (!req_ready_m && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) to = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_write = 1'($urandom); req_size = 3'($urandom); req_addr = 8'($urandom);
      req_wdata = {$urandom, $urandom};
      lat = 0;
      @(negedge clk);
      while (!rsp_valid_m && lat < 50) begin lat++; @(negedge clk); end
      if (lat >= 50) to = 1'b1;
      rd = rsp_rdata_m;
      er = rsp_error_m;
      @(posedge clk);
   endtask

   task automatic test_reset();
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         @(negedge clk);
         checks++;
         if (req_ready_m !== 1'b1) begin errors++; $display("FAIL reset_req_ready sel=%0d got=%b want=1", s, req_ready_m); end
         checks++;
         if (rsp_valid_m !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid sel=%0d got=%b want=0", s, rsp_valid_m); end
         checks++;
         if (rsp_rdata_m !== 64'd0) begin errors++; $display("FAIL reset_rsp_rdata sel=%0d got=%h want=0", s, rsp_rdata_m); end
         checks++;
         if (rsp_error_m !== 1'b0) begin errors++; $display("FAIL reset_rsp_error sel=%0d got=%b want=0", s, rsp_error_m); end
      end
      sel = 1'b0;
   endtask

   task automatic test_fill();
      logic [63:0] rd, erd, wd;
      logic er, eer;
      int lat;
      bit to;
      for (int a = 0; a < 256; a += 8) begin
         wd = {$urandom, $urandom};
         model_access(1'b1, 3'b011, 8'(a), wd, erd, eer);
         txn(1'b1, 3'b011, 8'(a), wd, rd, er, lat, to);
         checks++;
         if (to || er !== 1'b0 || rd !== 64'd0) begin
            errors++; $display("FAIL fill_sd addr=%0h got err=%b rdata=%h to=%0d want err=0 rdata=0", a, er, rd, to);
         end
      end
   endtask

   task automatic test_directed();
      logic [63:0] rd, erd;
      logic er, eer;
      int lat;
      bit to;
      logic [63:0] exp_v [4];
      logic [2:0]  ld_sz [4];
      logic [7:0]  ld_a  [4];
      exp_v = '{64'hFFFFFFFFFFFFFF88, 64'h0000000000000088, 64'hFFFFFFFFFFFF8877, 64'h0000000088776655};
      ld_sz = '{3'b000, 3'b100, 3'b001, 3'b110};
      ld_a  = '{8'h17, 8'h17, 8'h16, 8'h14};
      model_access(1'b1, 3'b011, 8'h10, 64'h8877665544332211, erd, eer);
      txn(1'b1, 3'b011, 8'h10, 64'h8877665544332211, rd, er, lat, to);
      txn(1'b0, 3'b011, 8'h10, 64'h0, rd, er, lat, to);
      checks++;
      if (to || lat != 3) begin errors++; $display("FAIL ld_latency got=%0d to=%0d want=3", lat, to); end
      checks++;
      if (rd !== 64'h8877665544332211 || er !== 1'b0) begin
         errors++; $display("FAIL ld_0x10 got=%h err=%b want=8877665544332211 err=0", rd, er);
      end
      for (int i = 0; i < 4; i++) begin
         txn(1'b0, ld_sz[i], ld_a[i], 64'h0, rd, er, lat, to);
         checks++;
         if (to || rd !== exp_v[i] || er !== 1'b0) begin
            errors++; $display("FAIL subword_load%0d got=%h err=%b want=%h err=0", i, rd, er, exp_v[i]);
         end
      end
      model_access(1'b1, 3'b000, 8'h11, 64'hDEADBEEFCAFE12AB, erd, eer);
      txn(1'b1, 3'b000, 8'h11, 64'hDEADBEEFCAFE12AB, rd, er, lat, to);
      txn(1'b0, 3'b011, 8'h10, 64'h0, rd, er, lat, to);
      checks++;
      if (to || rd !== 64'h887766554433AB11) begin
         errors++; $display("FAIL sb_lane got=%h want=887766554433ab11", rd);
      end
   endtask

   task automatic test_faults();
      logic [63:0] rd;
      logic er;
      int lat;
      bit to;
      bit          fw [3];
      logic [2:0]  fs [3];
      logic [7:0]  fa [3];
      fw = '{1'b0, 1'b1, 1'b1};
      fs = '{3'b010, 3'b001, 3'b100};
      fa = '{8'h12, 8'h13, 8'h10};
      for (int i = 0; i < 3; i++) begin
         txn(fw[i], fs[i], fa[i], 64'hFFFFFFFFFFFFFFFF, rd, er, lat, to);
         checks++;
         if (to || er !== 1'b1 || rd !== 64'd0) begin
            errors++; $display("FAIL fault%0d got err=%b rdata=%h want err=1 rdata=0", i, er, rd);
         end
      end
      txn(1'b0, 3'b011, 8'h10, 64'h0, rd, er, lat, to);
      checks++;
      if (to || rd !== 64'h887766554433AB11 || er !== 1'b0) begin
         errors++; $display("FAIL fault_mem_unchanged got=%h want=887766554433ab11", rd);
      end
   endtask

   task automatic test_random(input int count);
      logic [63:0] rd, erd, wd;
      logic er, eer;
      int lat;
      bit to;
      bit w;
      logic [2:0] sz;
      logic [7:0] a;
      for (int i = 0; i < count; i++) begin
         w  = 1'($urandom);
         sz = 3'($urandom_range(0, 7));
         a  = 8'($urandom);
         if ($urandom_range(0, 3) != 0) a = a & ~8'((1 << sz[1:0]) - 1);
         wd = {$urandom, $urandom};
         model_access(w, sz, a, wd, erd, eer);
         txn(w, sz, a, wd, rd, er, lat, to);
         checks++;
         if (to || rd !== erd || er !== eer || lat != exp_lat()) begin
            errors++;
            $display("FAIL random sel=%0d w=%0d sz=%0d a=%h got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
                     sel, w, sz, a, rd, er, lat, erd, eer, exp_lat());
         end
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] e1, e2;
      logic ee1, ee2;
      int lat;
      model_access(1'b0, 3'b011, 8'h10, 64'h0, e1, ee1);
      model_access(1'b0, 3'b010, 8'h14, 64'h0, e2, ee2);
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_size = 3'b011; req_addr = 8'h10;
      @(posedge clk);
      #1;
      req_size = 3'b010; req_addr = 8'h14;
      lat = 0;
      @(negedge clk);
      while (!rsp_valid_m && lat < 50) begin lat++; @(negedge clk); end
      checks++;
      if (lat != exp_lat() || rsp_rdata_m !== e1) begin
         errors++; $display("FAIL bp_first got rd=%h lat=%0d want rd=%h lat=%0d", rsp_rdata_m, lat, e1, exp_lat());
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid_m !== 1'b1 || rsp_rdata_m !== e1 || req_ready_m !== 1'b0) begin
            errors++; $display("FAIL bp_hold cyc=%0d got valid=%b rd=%h ready=%b want valid=1 rd=%h ready=0",
                               i, rsp_valid_m, rsp_rdata_m, req_ready_m, e1);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (req_ready_m !== 1'b1 || rsp_valid_m !== 1'b0) begin
         errors++; $display("FAIL bp_release got ready=%b valid=%b want ready=1 valid=0", req_ready_m, rsp_valid_m);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 0;
      @(negedge clk);
      while (!rsp_valid_m && lat < 50) begin lat++; @(negedge clk); end
      checks++;
      if (lat != exp_lat() || rsp_rdata_m !== e2 || rsp_error_m !== ee2) begin
         errors++; $display("FAIL bp_queued got rd=%h lat=%0d want rd=%h lat=%0d", rsp_rdata_m, lat, e2, exp_lat());
      end
      @(posedge clk);
   endtask

   task automatic test_reset_mid();
      logic [63:0] rd, erd;
      logic er, eer;
      int lat;
      bit to;
      model_access(1'b0, 3'b011, 8'h20, 64'h0, erd, eer);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 3'b011; req_addr = 8'h20; req_wdata = 64'h1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (req_ready_m !== 1'b1 || rsp_valid_m !== 1'b0) begin
         errors++; $display("FAIL rst_mid sel=%0d got ready=%b valid=%b want ready=1 valid=0", sel, req_ready_m, rsp_valid_m);
      end
      txn(1'b0, 3'b011, 8'h20, 64'h0, rd, er, lat, to);
      checks++;
      if (to || rd !== erd || er !== 1'b0) begin
         errors++; $display("FAIL rst_mid_store_dropped sel=%0d got=%h want=%h", sel, rd, erd);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      test_reset();
      rst = 1'b0;
      sel = 1'b0;
      test_fill();
      test_directed();
      test_faults();
      test_backpressure();
      test_random(80);
      test_reset_mid();
      sel = 1'b1;
      test_fill();
      test_backpressure();
      test_random(80);
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder side of the core's load/store interface: accepts one request at a time over a valid/ready channel and services it against a byte-addressed, little-endian RAM.
- Returns a response on a separate valid/ready channel after a programmable number of wait states.
- Replaces the zero-latency data memory so the multi-cycle core and its bench can exercise stalls, sub-word accesses and misalignment faults.

Parameters:
ADDRSIZE, 8, byte address width; RAM holds 2**ADDRSIZE bytes; legal range 3..16
WORDSIZE, 64, data width of request/response (fixed at 64; no other value is supported)
LATENCY, 2, wait-state cycles between request acceptance and response; 0..15

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_write  in  1  1 = store, 0 = load
req_size  in  3  RISC-V funct3: loads 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu; stores 000 sb, 001 sh, 010 sw, 011 sd
req_addr  in  ADDRSIZE  byte address
req_wdata  in  WORDSIZE  store data; only the low bytes for the access size are used
rsp_valid  out  1  response present
rsp_ready  in  1  core accepts response
rsp_rdata  out  WORDSIZE  load result, zero- or sign-extended per req_size; 0 for stores and errors
rsp_error  out  1  request faulted

Behaviour:
- Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, wait counter=0. RAM contents are not cleared.
- Handshake: a request is accepted on a rising edge with req_valid && req_ready. All request fields are captured at acceptance; inputs are ignored afterwards. A response transfers on an edge with rsp_valid && rsp_ready.
- FSM:
  - IDLE: req_ready=1. On acceptance, go to WAIT, load counter=LATENCY, drop req_ready. If LATENCY=0, go directly to EXEC.
  - WAIT: decrement counter each cycle; when it reaches 1, go to EXEC.
  - EXEC (one cycle): check the access, commit the store or read RAM, register rsp_rdata/rsp_error, go to RESP.
  - RESP: rsp_valid=1; outputs held stable until rsp_ready. On the handshake, go to IDLE, set rsp_valid=0, req_ready=1.
- Latency: request accepted at edge N produces rsp_valid high after edge N+LATENCY+1. With rsp_ready tied high, the next request can be accepted at edge N+LATENCY+3.
- No back-to-back overlap: req_ready is low from acceptance until the response handshake.
- Error conditions (rsp_error=1, rsp_rdata=0, RAM unchanged):
  - address not aligned to the access size (size bytes = 1 << req_size[1:0]);
  - load with req_size=111;
  - store with req_size[2]=1.
- Loads: assemble bytes addr..addr+size-1 little-endian. 000/001/010 sign-extend to 64 bits; 100/101/110 zero-extend; 011 takes the full 64 bits.
- Stores: write the low size bytes of req_wdata to addr..addr+size-1; other bytes are untouched. rsp_rdata=0, rsp_error=0.
- Aligned accesses never cross the top of RAM because the RAM size is a multiple of 8. No address wrap logic is needed.
- Reset mid-operation (WAIT/EXEC/RESP): return to IDLE at the next edge and drop any pending response. A store whose EXEC edge coincides with rst=1 is not committed. A store committed before rst stays committed.
- rsp_ready while rsp_valid=0 is ignored. req_valid while req_ready=0 is ignored and has no effect.

Decomposition:
- Package riscv_mem_pkg:
  - size encodings: SZ_B=000, SZ_H=001, SZ_W=010, SZ_D=011, SZ_BU=100, SZ_HU=101, SZ_WU=110;
  - FSM state enum: IDLE, WAIT, EXEC, RESP;
  - function size_bytes(funct3).
- One combinational sub-module, load_extend: takes the 8 raw bytes and req_size and produces the 64-bit extended result. It is reused later by the instruction-fetch responder.
- Byte-lane RAM and the FSM stay in the top module.

Test Plan:
- sd addr 0x10 wdata 0x8877665544332211, then ld 0x10 with LATENCY=2 -> first rsp_valid exactly 3 cycles after load acceptance; rdata 0x8877665544332211; error 0.
- After the above, lb 0x17 -> rdata 0xFFFFFFFFFFFFFF88; lbu 0x17 -> 0x0000000000000088; lh 0x16 -> 0xFFFFFFFFFFFF8877; lwu 0x14 -> 0x0000000088776655.
- sb 0x11 wdata 0xAB then ld 0x10 -> 0x887766554433AB11 (only one byte lane changed).
- lw 0x12, sh 0x13, and store with req_size=100 -> each gives rsp_error=1, rdata 0; a following ld 0x10 shows memory unchanged.
- Back-pressure: hold rsp_ready=0 for 5 cycles with req_valid held high -> rsp_valid/rdata stay stable, req_ready stays 0; raise rsp_ready -> req_ready=1 the next cycle and the queued request is accepted.
- Assert rst during WAIT of sd 0x20 wdata 0x1 -> next cycle req_ready=1, rsp_valid=0; subsequent ld 0x20 returns the prior contents. Repeat with LATENCY=0 for a zero-wait-state sanity check.
